// File: rtl/robo_pkg.sv
// robo_pkg: state encoding and command codes shared by the controller, map memory and benches
package robo_pkg;
   localparam logic [2:0] ST_IDLE = 3'd0, ST_SETTLE = 3'd1, ST_DECIDE = 3'd2,
                          ST_CMD = 3'd3, ST_DONE = 3'd4, ST_ERRO = 3'd5;
   typedef enum logic [2:0] {
      IDLE = ST_IDLE, SETTLE = ST_SETTLE, DECIDE = ST_DECIDE,
      CMD = ST_CMD, DONE = ST_DONE, ERRO = ST_ERRO
   } state_t;
   localparam logic [1:0] CMD_NONE = 2'd0, CMD_AVANCAR = 2'd1, CMD_GIRAR = 2'd2, CMD_REMOVER = 2'd3;
endpackage

// File: rtl/robo_espera.sv
// robo_espera: loadable down-counter; expired is high once CYCLES cycles have elapsed since load
module robo_espera #(
   parameter int CYCLES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic load,
   output logic expired
);
   localparam int W = CYCLES > 1 ? $clog2(CYCLES) : 1;
   logic [W-1:0] cnt;
   always_ff @(posedge clock)
      if (reset) cnt <= '0;
      else cnt <= load ? W'(CYCLES - 1) : (cnt != '0 ? cnt - 1'b1 : cnt);
   assign expired = cnt == '0;
endmodule

// File: rtl/robo_controle.sv
// robo_controle: left-hand wall follower issuing one-cycle avancar/girar/remover pulses to the map memory
module robo_controle
   import robo_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int MAX_STEPS     = 400,
   parameter int MAX_SPIN      = 4,
   parameter int STEP_W        = 10
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              head,
   input  logic              left,
   input  logic              under,
   input  logic              barrier,
   output logic              avancar,
   output logic              girar,
   output logic              remover,
   output logic              busy,
   output logic              done,
   output logic              erro,
   output logic [STEP_W-1:0] passos
);
   localparam int SPIN_W = $clog2(MAX_SPIN + 1);
   localparam logic [SPIN_W-1:0] SPIN_MAX = SPIN_W'(MAX_SPIN);
   localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(MAX_STEPS);
   state_t state, state_n;
   logic [1:0] cmd, cmd_n, rot_pend, rot_pend_n;
   logic virou, virou_n, expired, load;
   logic [SPIN_W-1:0] spin, spin_n;
   logic [STEP_W-1:0] passos_n;
   robo_espera #(.CYCLES(SETTLE_CYCLES)) u_espera (
      .clock(clock), .reset(reset), .load(load), .expired(expired)
   );
   always_ff @(posedge clock)
      if (reset) begin
         state    <= IDLE;
         cmd      <= CMD_NONE;
         rot_pend <= '0;
         virou    <= 1'b0;
         spin     <= '0;
         passos   <= '0;
      end else begin
         state    <= state_n;
         cmd      <= cmd_n;
         rot_pend <= rot_pend_n;
         virou    <= virou_n;
         spin     <= spin_n;
         passos   <= passos_n;
      end
   always_comb begin
      state_n    = state;
      cmd_n      = cmd;
      rot_pend_n = rot_pend;
      virou_n    = virou;
      spin_n     = spin;
      passos_n   = passos;
      case (state)
         IDLE, DONE, ERRO:
            if (start) begin
               state_n    = SETTLE;
               cmd_n      = CMD_NONE;
               rot_pend_n = '0;
               virou_n    = 1'b0;
               spin_n     = '0;
               passos_n   = '0;
            end
         // remaining left-turn pulses skip DECIDE entirely
         SETTLE:
            if (expired) begin
               state_n    = rot_pend != '0 ? CMD : DECIDE;
               rot_pend_n = rot_pend != '0 ? rot_pend - 2'd1 : rot_pend;
            end
         DECIDE:
            if (under) state_n = DONE;
            else if (barrier) begin
               state_n = CMD;
               cmd_n   = CMD_REMOVER;
               spin_n  = '0;
            end else if (!left && !virou) begin
               state_n    = spin == SPIN_MAX ? ERRO : CMD;
               cmd_n      = CMD_GIRAR;
               rot_pend_n = spin == SPIN_MAX ? rot_pend : 2'd2;
               virou_n    = 1'b1;
               spin_n     = spin == SPIN_MAX ? spin : spin + 1'b1;
            end else if (!head) begin
               state_n  = passos == STEP_MAX ? ERRO : CMD;
               cmd_n    = CMD_AVANCAR;
               virou_n  = 1'b0;
               spin_n   = '0;
               passos_n = passos == STEP_MAX ? passos : passos + 1'b1;
            end else begin
               state_n = spin == SPIN_MAX ? ERRO : CMD;
               cmd_n   = CMD_GIRAR;
               virou_n = 1'b0;
               spin_n  = spin == SPIN_MAX ? spin : spin + 1'b1;
            end
         CMD: state_n = SETTLE;
         default: state_n = IDLE;
      endcase
   end
   assign load    = state_n == SETTLE && state != SETTLE;
   assign avancar = state == CMD && cmd == CMD_AVANCAR;
   assign girar   = state == CMD && cmd == CMD_GIRAR;
   assign remover = state == CMD && cmd == CMD_REMOVER;
   assign busy    = state == SETTLE || state == DECIDE || state == CMD;
   assign done    = state == DONE;
   assign erro    = state == ERRO;
endmodule

// File: tb/tb_robo_controle.sv
// tb_robo_controle: timeline reference model plus directed vector table for robo_controle
module tb_robo_controle;
   localparam int S = 2, MS = 400, MSP = 4;
   logic clock = 1'b0;
   always #5 clock = ~clock;
   logic reset = 1'b1, start = 1'b0, head = 1'b0, left = 1'b0, under = 1'b0, barrier = 1'b0;
   logic avancar, girar, remover, busy, done, erro;
   logic [9:0] passos;
   logic reset3 = 1'b1, start3 = 1'b0;
   logic av3, gi3, re3, busy3, done3, erro3;
   logic [9:0] passos3;
   robo_controle dut (
      .clock(clock), .reset(reset), .start(start), .head(head), .left(left), .under(under),
      .barrier(barrier), .avancar(avancar), .girar(girar), .remover(remover), .busy(busy),
      .done(done), .erro(erro), .passos(passos)
   );
   robo_controle #(.MAX_STEPS(3)) dut3 (
      .clock(clock), .reset(reset3), .start(start3), .head(head), .left(left), .under(under),
      .barrier(barrier), .avancar(av3), .girar(gi3), .remover(re3), .busy(busy3),
      .done(done3), .erro(erro3), .passos(passos3)
   );
   int checks = 0, errors = 0;
   // model: mode 0 idle, 1 running, 2 done, 3 erro; pulses scheduled by absolute edge number
   typedef struct {int t; int k;} pulse_t;
   pulse_t q[$];
   int now = 0, mode = 0, dec_at = 0, m_passos = 0, m_spin = 0, exp_k = 0;
   bit m_virou = 0;
   int av_c, gi_c, rm_c, av3_c;
   task automatic push(input int t, input int k);
      pulse_t p;
      p.t = t;
      p.k = k;
      q.push_back(p);
   endtask
   task automatic decide();
      if (under) mode = 2;
      else if (barrier) begin
         push(now, 3); m_spin = 0; dec_at = now + S + 2;
      end else if (!left && !m_virou) begin
         if (m_spin == MSP) mode = 3;
         else begin
            for (int i = 0; i < 3; i++) push(now + i * (S + 1), 2);
            m_virou = 1; m_spin++; dec_at = now + 2 * (S + 1) + S + 2;
         end
      end else if (!head) begin
         if (m_passos == MS) mode = 3;
         else begin
            push(now, 1); m_passos++; m_virou = 0; m_spin = 0; dec_at = now + S + 2;
         end
      end else begin
         if (m_spin == MSP) mode = 3;
         else begin
            push(now, 2); m_virou = 0; m_spin++; dec_at = now + S + 2;
         end
      end
   endtask
   task automatic model_step();
      now++;
      exp_k = 0;
      if (reset) begin
         mode = 0; q.delete(); m_passos = 0; m_spin = 0; m_virou = 0;
      end else if (mode != 1) begin
         if (start) begin
            mode = 1; m_passos = 0; m_spin = 0; m_virou = 0; dec_at = now + S + 1;
         end
      end else if (now == dec_at) decide();
      if (q.size() > 0 && q[0].t == now) begin
         exp_k = q[0].k;
         void'(q.pop_front());
      end
   endtask
   task automatic tick();
      logic [15:0] got, exp_v;
      @(posedge clock);
      model_step();
      @(negedge clock);
      got   = {avancar, girar, remover, busy, done, erro, passos};
      exp_v = {exp_k == 1, exp_k == 2, exp_k == 3, mode == 1, mode == 2, mode == 3, 10'(m_passos)};
      checks++;
      if (got !== exp_v) begin
         errors++;
         $display("FAIL model edge %0d got {av,gi,rm,busy,done,erro,passos}=%h required %h", now, got, exp_v);
      end
      av_c += int'(avancar); gi_c += int'(girar); rm_c += int'(remover); av3_c += int'(av3);
   endtask
   task automatic chk(input string n, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d required %0d", n, got, want);
      end
   endtask
   task automatic begin_run(input bit h, input bit l, input bit u, input bit b);
      head = h; left = l; under = u; barrier = b;
      reset = 1; start = 0;
      tick();
      reset = 0; start = 1;
      av_c = 0; gi_c = 0; rm_c = 0;
      tick();
      start = 0;
   endtask
   typedef struct {bit h, l, u, b; int k, av, gi, rm, dn, er, ps, bs;} vec_t;
   vec_t tbl[6];
   initial begin
      tbl[0] = '{0, 1, 1, 0, 10, 0, 0, 0, 1, 0, 0, 0};
      tbl[1] = '{0, 1, 0, 0, 22, 5, 0, 0, 0, 0, 5, 1};
      tbl[2] = '{1, 1, 0, 0, 25, 0, 4, 0, 0, 1, 0, 0};
      tbl[3] = '{0, 0, 0, 0, 22, 1, 5, 0, 0, 0, 1, 1};
      tbl[4] = '{0, 1, 0, 1, 22, 0, 0, 5, 0, 0, 0, 1};
      tbl[5] = '{1, 0, 0, 0, 40, 0, 8, 0, 0, 1, 0, 0};
      av_c = 0; gi_c = 0; rm_c = 0; av3_c = 0;
      tick(); tick();
      reset3 = 0;
      chk("reset_outputs", int'({avancar, girar, remover, busy, done, erro}), 0);
      chk("reset_passos", int'(passos), 0);
      for (int r = 0; r < 6; r++) begin
         begin_run(tbl[r].h, tbl[r].l, tbl[r].u, tbl[r].b);
         repeat (tbl[r].k - 1) tick();
         chk($sformatf("row%0d_avancar", r), av_c, tbl[r].av);
         chk($sformatf("row%0d_girar", r), gi_c, tbl[r].gi);
         chk($sformatf("row%0d_remover", r), rm_c, tbl[r].rm);
         chk($sformatf("row%0d_done", r), int'(done), tbl[r].dn);
         chk($sformatf("row%0d_erro", r), int'(erro), tbl[r].er);
         chk($sformatf("row%0d_passos", r), int'(passos), tbl[r].ps);
         chk($sformatf("row%0d_busy", r), int'(busy), tbl[r].bs);
      end
      begin_run(0, 1, 1, 0);
      tick(); tick();
      chk("first_decide_not_yet", int'(done), 0);
      tick();
      chk("first_decide_done", int'(done), 1);
      chk("first_decide_no_pulse", av_c + gi_c + rm_c, 0);
      begin_run(0, 1, 0, 1);
      tick(); tick(); tick();
      chk("barrier_remover", int'(remover), 1);
      barrier = 0;
      tick(); tick(); tick();
      chk("barrier_gap", av_c, 0);
      tick();
      chk("barrier_then_avancar", int'(avancar), 1);
      chk("barrier_single_remover", rm_c, 1);
      begin_run(0, 0, 0, 0);
      tick(); tick(); tick();
      chk("turn_first_girar", int'(girar), 1);
      tick();
      reset = 1;
      tick();
      chk("midturn_reset_outputs", int'({avancar, girar, remover, busy, done, erro}), 0);
      reset = 0;
      gi_c = 0; av_c = 0;
      repeat (10) tick();
      chk("midturn_no_pulses", gi_c + av_c, 0);
      head = 0; left = 1; under = 0; barrier = 0;
      start3 = 1; av3_c = 0;
      tick();
      start3 = 0;
      repeat (19) tick();
      chk("max3_avancar", av3_c, 3);
      chk("max3_erro", int'(erro3), 1);
      chk("max3_passos", int'(passos3), 3);
      start3 = 1;
      tick();
      start3 = 0;
      chk("restart_erro_clear", int'(erro3), 0);
      chk("restart_passos_clear", int'(passos3), 0);
      chk("restart_busy", int'(busy3), 1);
      for (int c = 0; c < 3000; c++) begin
         reset   = $urandom_range(0, 299) == 0;
         start   = mode != 1 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 1) == 1;
         under   = $urandom_range(0, 39) == 0;
         barrier = $urandom_range(0, 7) == 0;
         head    = $urandom_range(0, 1) == 1;
         left    = $urandom_range(0, 1) == 1;
         tick();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
